// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: forwarding, operand 2, ALU, flags, branch target, iterative multiplier
module exe_stage #(
    parameter int ADDRESS_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESS_LEN-1:0] pc,
    input  logic                   S,
    input  logic                   B,
    input  logic                   MEM_W_EN,
    input  logic                   MEM_R_EN,
    input  logic                   WB_EN,
    input  logic                   imm,
    input  logic [3:0]             EXE_CMD,
    input  logic [ADDRESS_LEN-1:0] Val_Rn,
    input  logic [ADDRESS_LEN-1:0] Val_Rm,
    input  logic [23:0]            Signed_imm_24,
    input  logic [11:0]            Shift_operand,
    input  logic [3:0]             Dest,
    input  logic [1:0]             sel_src1,
    input  logic [1:0]             sel_src2,
    input  logic [ADDRESS_LEN-1:0] MEM_ALU_Res,
    input  logic [ADDRESS_LEN-1:0] WB_Value,
    output logic [ADDRESS_LEN-1:0] ALU_Res,
    output logic [ADDRESS_LEN-1:0] Val_Rm_out,
    output logic [3:0]             Dest_out,
    output logic                   WB_EN_out,
    output logic                   MEM_R_EN_out,
    output logic                   MEM_W_EN_out,
    output logic                   B_out,
    output logic [ADDRESS_LEN-1:0] Branch_Address,
    output logic [3:0]             status_out,
    output logic                   freeze
);
    localparam int W = ADDRESS_LEN;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     status_q, status_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [5:0]     cnt_q, cnt_d;

    logic [W-1:0]   val1, rm_fwd, val2, result, imm8;
    logic [W:0]     sum;
    logic [4:0]     rot_amt, sh_amt;
    logic           c_new, v_new, is_add, is_sub, mul_issue;

    assign mul_issue = (EXE_CMD == 4'b1010) && WB_EN;

    // Forwarding muxes; select 11 falls back to the ID value
    always_comb begin
        case (sel_src1)
            2'b01:   val1 = MEM_ALU_Res;
            2'b10:   val1 = WB_Value;
            default: val1 = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   rm_fwd = MEM_ALU_Res;
            2'b10:   rm_fwd = WB_Value;
            default: rm_fwd = Val_Rm;
        endcase
    end

    // Operand 2: memory offset, rotated immediate, or shifted register
    always_comb begin
        imm8    = {{(W-8){1'b0}}, Shift_operand[7:0]};
        rot_amt = {Shift_operand[11:8], 1'b0};
        sh_amt  = Shift_operand[11:7];
        if (MEM_R_EN || MEM_W_EN) begin
            val2 = {{(W-12){1'b0}}, Shift_operand};
        end else if (imm) begin
            val2 = (imm8 >> rot_amt) | (imm8 << (6'(W) - {1'b0, rot_amt}));
        end else begin
            case (Shift_operand[6:5])
                2'b00:   val2 = rm_fwd << sh_amt;
                2'b01:   val2 = rm_fwd >> sh_amt;
                2'b10:   val2 = $unsigned($signed(rm_fwd) >>> sh_amt);
                default: val2 = (rm_fwd >> sh_amt) | (rm_fwd << (6'(W) - {1'b0, sh_amt}));
            endcase
        end
    end

    // ALU; arithmetic ops take C/V from the W+1 bit sum, others keep them
    always_comb begin
        sum    = '0;
        result = '0;
        is_add = 1'b0;
        is_sub = 1'b0;
        c_new  = status_q[2];
        v_new  = status_q[1];
        case (EXE_CMD)
            4'b0001: result = val2;
            4'b1001: result = ~val2;
            4'b0010: begin
                sum    = {1'b0, val1} + {1'b0, val2};
                is_add = 1'b1;
            end
            4'b0011: begin
                sum    = {1'b0, val1} + {1'b0, val2} + {{W{1'b0}}, status_q[2]};
                is_add = 1'b1;
            end
            4'b0100: begin
                sum    = {1'b0, val1} + {1'b0, ~val2} + {{W{1'b0}}, 1'b1};
                is_sub = 1'b1;
            end
            4'b0101: begin
                sum    = {1'b0, val1} + {1'b0, ~val2} + {{W{1'b0}}, status_q[2]};
                is_sub = 1'b1;
            end
            4'b0110: result = val1 & val2;
            4'b0111: result = val1 | val2;
            4'b1000: result = val1 ^ val2;
            4'b1010: result = acc_q;
            default: result = '0;
        endcase
        if (is_add || is_sub) begin
            result = sum[W-1:0];
            c_new  = sum[W];
            if (is_add) v_new = (val1[W-1] == val2[W-1]) && (sum[W-1] != val1[W-1]);
            else        v_new = (val1[W-1] != val2[W-1]) && (sum[W-1] != val1[W-1]);
        end
    end

    // Flags {Z,C,V,N} update only when an S instruction leaves EXE this cycle
    always_comb begin
        status_d = status_q;
        if (S && !freeze) status_d = {result == '0, c_new, v_new, result[W-1]};
    end

    // Shift-add multiplier sequencer; freeze holds the pipeline from issue to last step
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_issue) begin
                    freeze   = 1'b1;
                    mcand_d  = val1;
                    mplier_d = rm_fwd;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                freeze = 1'b1;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ALU_Res        = result;
    assign Val_Rm_out     = rm_fwd;
    assign Dest_out       = Dest;
    assign WB_EN_out      = WB_EN & ~freeze;
    assign MEM_R_EN_out   = MEM_R_EN & ~freeze;
    assign MEM_W_EN_out   = MEM_W_EN & ~freeze;
    assign B_out          = B & ~freeze;
    assign Branch_Address = pc + {{(W-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign status_out     = status_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage
module tb_exe_stage;
    logic        clk, rst;
    logic [31:0] pc;
    logic        S, B, MEM_W_EN, MEM_R_EN, WB_EN, imm;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val_Rn, Val_Rm;
    logic [23:0] Signed_imm_24;
    logic [11:0] Shift_operand;
    logic [3:0]  Dest;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] MEM_ALU_Res, WB_Value;
    logic [31:0] ALU_Res, Val_Rm_out, Branch_Address;
    logic [3:0]  Dest_out, status_out;
    logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, freeze;

    int checks = 0;
    int errors = 0;

    exe_stage #(.ADDRESS_LEN(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .S(S), .B(B), .MEM_W_EN(MEM_W_EN),
        .MEM_R_EN(MEM_R_EN), .WB_EN(WB_EN), .imm(imm), .EXE_CMD(EXE_CMD),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Signed_imm_24(Signed_imm_24),
        .Shift_operand(Shift_operand), .Dest(Dest), .sel_src1(sel_src1),
        .sel_src2(sel_src2), .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
        .ALU_Res(ALU_Res), .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .B_out(B_out), .Branch_Address(Branch_Address), .status_out(status_out),
        .freeze(freeze)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] idv,
                                          input logic [31:0] memv, input logic [31:0] wbv);
        if (s == 2'b01) return memv;
        if (s == 2'b10) return wbv;
        return idv;
    endfunction

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic logic [31:0] m_val2(input logic memrw, input logic im,
                                           input logic [11:0] so, input logic [31:0] rm);
        int amt;
        amt = int'(so[11:7]);
        if (memrw) return {20'd0, so};
        if (im) return m_rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
        case (so[6:5])
            2'b00:   return rm << amt;
            2'b01:   return rm >> amt;
            2'b10:   return $unsigned($signed(rm) >>> amt);
            default: return m_rotr(rm, amt);
        endcase
    endfunction

    // status is {Z,C,V,N}
    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] st, output logic [31:0] res, output logic [3:0] st_new);
        logic c, v;
        longint ua, ub, sa, sb, t, ts, cin;
        c   = st[2];
        v   = st[1];
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cin = st[2] ? 64'sd1 : 64'sd0;
        res = 32'd0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0010, 4'b0011: begin
                t   = ua + ub + ((cmd == 4'b0011) ? cin : 64'sd0);
                ts  = sa + sb + ((cmd == 4'b0011) ? cin : 64'sd0);
                res = t[31:0];
                c   = t > 64'sd4294967295;
                v   = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                t   = ua - ub - ((cmd == 4'b0101) ? (64'sd1 - cin) : 64'sd0);
                ts  = sa - sb - ((cmd == 4'b0101) ? (64'sd1 - cin) : 64'sd0);
                res = t[31:0];
                c   = t >= 0;
                v   = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
            end
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: res = 32'd0;
        endcase
        st_new = {res == 32'd0, c, v, res[31]};
    endtask

    // phase: 0 = no multiply in flight, k = cycles since issue (1..33)
    int          m_phase = 0;
    logic [3:0]  m_status = 4'd0;
    logic [31:0] m_mul = 32'd0;

    // Compare process: checks every output against the model each cycle outside reset
    initial begin
        logic [31:0] a, rm, b2, eres;
        logic [63:0] prod;
        logic [3:0]  est_new;
        logic        issuing, efz, alu_ok;
        int          nphase;
        logic [3:0]  nstatus;
        logic [31:0] nmul;
        forever begin
            @(negedge clk);
            a       = m_fwd(sel_src1, Val_Rn, MEM_ALU_Res, WB_Value);
            rm      = m_fwd(sel_src2, Val_Rm, MEM_ALU_Res, WB_Value);
            b2      = m_val2(MEM_R_EN | MEM_W_EN, imm, Shift_operand, rm);
            issuing = (EXE_CMD == 4'b1010) && WB_EN;
            efz     = (m_phase == 0 && issuing) || (m_phase >= 1 && m_phase <= 32);
            if (EXE_CMD == 4'b1010) begin
                eres    = m_mul;
                est_new = {m_mul == 32'd0, m_status[2], m_status[1], m_mul[31]};
                alu_ok  = (m_phase == 33);
            end else begin
                m_alu(EXE_CMD, a, b2, m_status, eres, est_new);
                alu_ok = !efz;
            end
            if (!rst) begin
                chk("freeze", {31'd0, freeze}, {31'd0, efz});
                chk("wb_en_out", {31'd0, WB_EN_out}, {31'd0, WB_EN & !efz});
                chk("mem_r_en_out", {31'd0, MEM_R_EN_out}, {31'd0, MEM_R_EN & !efz});
                chk("mem_w_en_out", {31'd0, MEM_W_EN_out}, {31'd0, MEM_W_EN & !efz});
                chk("b_out", {31'd0, B_out}, {31'd0, B & !efz});
                chk("branch_address", Branch_Address,
                    pc + 32'(longint'($signed(Signed_imm_24)) * 4));
                chk("status_out", {28'd0, status_out}, {28'd0, m_status});
                chk("val_rm_out", Val_Rm_out, rm);
                chk("dest_out", {28'd0, Dest_out}, {28'd0, Dest});
                if (alu_ok) chk("alu_res", ALU_Res, eres);
            end
            nphase  = m_phase;
            nstatus = m_status;
            nmul    = m_mul;
            if (rst) begin
                nphase  = 0;
                nstatus = 4'd0;
            end else begin
                if (S && !efz) nstatus = est_new;
                if (m_phase == 0 && issuing) begin
                    prod   = {32'd0, a} * {32'd0, rm};
                    nmul   = prod[31:0];
                    nphase = 1;
                end else if (m_phase >= 1 && m_phase <= 32) begin
                    nphase = m_phase + 1;
                end else if (m_phase == 33) begin
                    nphase = 0;
                end
            end
            @(posedge clk);
            m_phase  = nphase;
            m_status = nstatus;
            m_mul    = nmul;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nextcyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        pc = 32'd0; S = 0; B = 0; MEM_W_EN = 0; MEM_R_EN = 0; WB_EN = 0; imm = 0;
        EXE_CMD = 4'd0; Val_Rn = 32'd0; Val_Rm = 32'd0; Signed_imm_24 = 24'd0;
        Shift_operand = 12'd0; Dest = 4'd0; sel_src1 = 2'b00; sel_src2 = 2'b00;
        MEM_ALU_Res = 32'd0; WB_Value = 32'd0;
    endtask

    task automatic alu_op(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                          input logic [31:0] rmv, input logic im, input logic [11:0] so);
        nop();
        EXE_CMD = cmd; S = s; Val_Rn = rn; Val_Rm = rmv; imm = im; Shift_operand = so;
        WB_EN = 1; Dest = 4'd3;
    endtask

    initial begin
        int fcnt;
        logic wb_bad;
        rst = 1;
        nop();
        repeat (2) nextcyc();
        rst = 0;
        sample();
        chk("reset_freeze", {31'd0, freeze}, 32'd0);
        chk("reset_status", {28'd0, status_out}, 32'd0);

        // MOV R1,#0xFF ror 2
        nextcyc(); alu_op(4'b0001, 1'b0, 32'd0, 32'd0, 1'b1, 12'h1FF);
        sample();
        chk("mov_imm_rot", ALU_Res, 32'hC000003F);
        chk("mov_wb_en", {31'd0, WB_EN_out}, 32'd1);

        // ADDS overflow
        nextcyc(); alu_op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 12'h000);
        sample();
        chk("mov_no_flag_write", {28'd0, status_out}, 32'd0);
        chk("adds_res", ALU_Res, 32'h80000000);

        // SUBS 5-5
        nextcyc(); alu_op(4'b0100, 1'b1, 32'd5, 32'd5, 1'b0, 12'h000);
        sample();
        chk("adds_flags", {28'd0, status_out}, 32'b0011);

        // ADC 3+4 with C=1
        nextcyc(); alu_op(4'b0011, 1'b0, 32'd3, 32'd4, 1'b0, 12'h000);
        sample();
        chk("subs_flags", {28'd0, status_out}, 32'b1100);
        chk("adc_res", ALU_Res, 32'd8);

        // forwarding from MEM into Rn
        nextcyc(); alu_op(4'b0010, 1'b0, 32'h999, 32'd1, 1'b0, 12'h000);
        sel_src1 = 2'b01; MEM_ALU_Res = 32'h10;
        sample();
        chk("fwd_mem_rn", ALU_Res, 32'h11);

        // shifted-register operand 2, all four types, amount 4, forwarded from WB
        for (int t = 0; t < 4; t++) begin
            nextcyc(); alu_op(4'b0001, 1'b0, 32'd0, 32'h0, 1'b0, 12'(((4 << 2) | t) << 5));
            sel_src2 = 2'b10; WB_Value = 32'h8000_0013;
        end
        sample();
        chk("ror4_wb", ALU_Res, 32'h3800_0001);
        // sel 11 behaves as 00, ROR amount 0 is no shift, EOR
        nextcyc(); alu_op(4'b1000, 1'b0, 32'hF0F0_F0F0, 32'h1234_5678, 1'b0, 12'h060);
        sel_src1 = 2'b11; sel_src2 = 2'b11; MEM_ALU_Res = 32'hDEAD; WB_Value = 32'hBEEF;
        // STR: offset operand, store data is forwarded Rm
        nextcyc(); alu_op(4'b0010, 1'b0, 32'h1000, 32'hCAFE, 1'b0, 12'h123);
        MEM_W_EN = 1; WB_EN = 0;
        sample();
        chk("str_addr", ALU_Res, 32'h1123);
        // LDR, ASR, MVN, ORR, AND, SBC
        nextcyc(); alu_op(4'b0010, 1'b0, 32'h2000, 32'd0, 1'b0, 12'hFFF); MEM_R_EN = 1;
        nextcyc(); alu_op(4'b1001, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 12'h0C0);
        nextcyc(); alu_op(4'b0111, 1'b0, 32'h00FF_0000, 32'h0000_00F0, 1'b1, 12'h4F0);
        nextcyc(); alu_op(4'b0110, 1'b0, 32'hFFFF_0F0F, 32'h0000_FFFF, 1'b0, 12'h000);
        nextcyc(); alu_op(4'b0101, 1'b0, 32'd10, 32'd3, 1'b0, 12'h000);
        sample();
        chk("sbc_c1", ALU_Res, 32'd7);

        // branch
        nextcyc(); nop(); pc = 32'h100; Signed_imm_24 = 24'hFFFFFE; B = 1;
        sample();
        chk("branch_addr", Branch_Address, 32'hF8);
        chk("branch_taken", {31'd0, B_out}, 32'd1);

        // MULS 0xFFFFFFFF * 3
        nextcyc(); alu_op(4'b1010, 1'b1, 32'hFFFFFFFF, 32'd3, 1'b0, 12'h000);
        fcnt = 0; wb_bad = 0;
        for (int k = 0; k < 50; k++) begin
            sample();
            if (!freeze) break;
            fcnt++;
            if (WB_EN_out) wb_bad = 1;
        end
        chk("mul_freeze_cycles", fcnt, 33);
        chk("mul_wb_bubble", {31'd0, wb_bad}, 32'd0);
        chk("mul_done_res", ALU_Res, 32'hFFFFFFFD);
        chk("mul_done_wb_en", {31'd0, WB_EN_out}, 32'd1);
        nextcyc(); nop();
        sample();
        chk("muls_flags", {28'd0, status_out}, 32'b0101);

        // abort a multiply with reset in BUSY cycle 10
        nextcyc(); alu_op(4'b1010, 1'b0, 32'd7, 32'd9, 1'b0, 12'h000);
        repeat (10) nextcyc();
        sample();
        chk("busy_freeze", {31'd0, freeze}, 32'd1);
        nextcyc(); rst = 1; nop();
        nextcyc(); rst = 0;
        sample();
        chk("abort_freeze", {31'd0, freeze}, 32'd0);
        chk("abort_status", {28'd0, status_out}, 32'd0);
        chk("abort_no_wb", {31'd0, WB_EN_out}, 32'd0);

        repeat (3) nextcyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
